// File: rtl/shift_add_mul_seq_if.sv
// -----------------------------------------------------------------------------
// shift_add_mul_seq_if
//   Request/response bundle for the iterative shift-and-add multiplier.
//   The requester (master) drives start/is_signed/a/b and observes
//   busy/done/product; the multiplier (slave) does the reverse.
//
//   Parameter
//     WIDTH      operand width; product is 2*WIDTH bits. Must match the
//                WIDTH of the shift_add_mul_seq instance it connects to.
//   Signals
//     start      request, sampled by the multiplier only while busy=0
//     is_signed  1 = two's-complement operands, 0 = unsigned
//     a, b       multiplicand / multiplier, sampled with start
//     busy       operation in progress
//     done       one-cycle pulse when product is updated
//     product    result, held until the next operation completes
// -----------------------------------------------------------------------------
interface shift_add_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_mul_seq.sv
// -----------------------------------------------------------------------------
// shift_add_mul_seq
//   Iterative shift-and-add integer multiplier, one multiplier bit per clock.
//   Signed operands are reduced to unsigned magnitudes on acceptance; the
//   sign of the product is re-applied in a final cycle, so the core loop is
//   a plain unsigned multiply and the full 2*WIDTH product is always exact.
//
//   Parameter
//     WIDTH   operand width (4..64), product is 2*WIDTH bits
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset (aborts any operation)
//     bus     shift_add_mul_seq_if.slave: start/is_signed/a/b in,
//             busy/done/product out
//
//   Optional build macro
//     SHIFT_ADD_MUL_EARLY_TERM_EN  finish as soon as the remaining multiplier
//                                  bits are all zero (latency depends on b);
//                                  undefined = fixed WIDTH+1 edge latency.
// -----------------------------------------------------------------------------
module shift_add_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_add_mul_seq_if.slave bus
);

  localparam int                PW   = 2 * WIDTH;
  localparam int                CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [CW-1:0]     r_cnt;
  logic              r_neg;
  logic              r_busy;
  logic              r_done;
  logic [PW-1:0]     r_product;

  logic [WIDTH-1:0]  w_a_mag;
  logic [WIDTH-1:0]  w_b_mag;
  logic [PW-1:0]     w_acc_add;
  logic [PW-1:0]     w_mcand_shl;
  logic [WIDTH-1:0]  w_mplier_shr;

  // Unsigned magnitude of an operand. The result is read as unsigned, so
  // the most negative value maps onto 2^(WIDTH-1) without overflow.
  function automatic logic [WIDTH-1:0] operand_mag(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
    logic [WIDTH-1:0] m;
    m = v;
    if (sgn && v[WIDTH-1])
      m = ~v + WIDTH'(1);
    return m;
  endfunction

  // Two's-complement negate of the accumulated magnitude, modulo 2^PW.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v,
                                               input logic          neg);
    logic [PW-1:0] r;
    r = v;
    if (neg)
      r = ~v + PW'(1);
    return r;
  endfunction

  assign w_a_mag      = operand_mag(bus.a, bus.is_signed);
  assign w_b_mag      = operand_mag(bus.b, bus.is_signed);
  assign w_acc_add    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mcand_shl  = {r_mcand[PW-2:0], 1'b0};
  assign w_mplier_shr = {1'b0, r_mplier[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CALC;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
            // Nothing to accumulate: skip the loop, acc is already 0.
            if (w_b_mag == '0)
              r_state <= FIN;
`endif
          end
        end

        CALC: begin
          r_acc    <= w_acc_add;
          r_mcand  <= w_mcand_shl;
          r_mplier <= w_mplier_shr;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST)
            r_state <= FIN;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
          // Remaining multiplier bits are all zero: acc can no longer change.
          if (w_mplier_shr == '0)
            r_state <= FIN;
`endif
        end

        FIN: begin
          r_product <= apply_sign(r_acc, r_neg);
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;

endmodule

// File: tb/tb_shift_add_mul_seq.sv
module tb_shift_add_mul_seq;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] q32[$];
  logic [15:0] q8[$];

  shift_add_mul_seq_if #(.WIDTH(32)) bus32();
  shift_add_mul_seq_if #(.WIDTH(8))  bus8();

  shift_add_mul_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  shift_add_mul_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] model32(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (s) return sa * sb;
    return ua * ub;
  endfunction

  function automatic logic [15:0] model8(input bit s, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    logic [15:0] ua, ub;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    ua = {8'b0, a};
    ub = {8'b0, b};
    if (s) return sa * sb;
    return ua * ub;
  endfunction

  function automatic int exp_lat(input int w, input bit s, input logic [63:0] b);
    int lat;
    lat = w + 1;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    begin
      logic [63:0] m;
      int k;
      m = b;
      if (s && b[w-1]) m = (~b + 64'd1);
      k = -1;
      for (int i = 0; i < w; i++) if (m[i]) k = i;
      lat = (k < 0) ? 1 : k + 2;
    end
`endif
    return lat;
  endfunction

  // ---------------- drivers ----------------
  task automatic issue32(input bit s, input logic [31:0] a, input logic [31:0] b);
    bus32.is_signed = s;
    bus32.a         = a;
    bus32.b         = b;
    bus32.start     = 1'b1;
    q32.push_back(model32(s, a, b));
    @(posedge clk); #1;
    bus32.start = 1'b0;
  endtask

  task automatic issue8(input bit s, input logic [7:0] a, input logic [7:0] b);
    bus8.is_signed = s;
    bus8.a         = a;
    bus8.b         = b;
    bus8.start     = 1'b1;
    q8.push_back(model8(s, a, b));
    @(posedge clk); #1;
    bus8.start = 1'b0;
  endtask

  // Called 1ns after the start edge; returns edges until done and busy cycles.
  // A nonzero pulse_at re-pulses start with a=b=9 at that edge (must be ignored).
  task automatic wait32(input int pulse_at, output int edges, output int busyc);
    edges = 0;
    busyc = bus32.busy ? 1 : 0;
    while (edges < 100) begin
      @(posedge clk); edges++; #1;
      if (pulse_at != 0 && edges == pulse_at) begin
        bus32.start = 1'b1; bus32.a = 32'd9; bus32.b = 32'd9; bus32.is_signed = 1'b0;
      end
      if (pulse_at != 0 && edges == pulse_at + 1) bus32.start = 1'b0;
      if (bus32.done) break;
      if (bus32.busy) busyc++;
    end
  endtask

  task automatic wait8(output int edges);
    edges = 0;
    while (edges < 100) begin
      @(posedge clk); edges++; #1;
      if (bus8.done) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    bus32.start = 0; bus32.is_signed = 0; bus32.a = 0; bus32.b = 0;
    bus8.start  = 0; bus8.is_signed  = 0; bus8.a  = 0; bus8.b  = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus32.busy !== 1'b0) $display("FAIL reset_busy32: got %b want 0", bus32.busy); else n_pass++;
    n_checks++; if (bus32.done !== 1'b0) $display("FAIL reset_done32: got %b want 0", bus32.done); else n_pass++;
    n_checks++; if (bus32.product !== 64'd0) $display("FAIL reset_product32: got %h want 0", bus32.product); else n_pass++;
    n_checks++; if (bus8.busy !== 1'b0) $display("FAIL reset_busy8: got %b want 0", bus8.busy); else n_pass++;
    n_checks++; if (bus8.done !== 1'b0) $display("FAIL reset_done8: got %b want 0", bus8.done); else n_pass++;
    n_checks++; if (bus8.product !== 16'd0) $display("FAIL reset_product8: got %h want 0", bus8.product); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    logic [31:0] ta[3] = '{32'd2, 32'd125, 32'hFFFF_FFFF};
    logic [31:0] tb[3] = '{32'd23, 32'd25, 32'hFFFF_FFFF};
    int edges, busyc;
    logic [63:0] exp;
    for (int i = 0; i < 3; i++) begin
      issue32(1'b0, ta[i], tb[i]);
      wait32(0, edges, busyc);
      exp = 'x;
      if (q32.size() != 0) exp = q32.pop_front();
      n_checks++; if (bus32.product !== exp) $display("FAIL unsigned_product[%0d]: got %h want %h", i, bus32.product, exp); else n_pass++;
      n_checks++; if (edges != exp_lat(32, 1'b0, {32'b0, tb[i]})) $display("FAIL unsigned_latency[%0d]: got %0d want %0d", i, edges, exp_lat(32, 1'b0, {32'b0, tb[i]})); else n_pass++;
      n_checks++; if (busyc != exp_lat(32, 1'b0, {32'b0, tb[i]}) || bus32.busy !== 1'b0) $display("FAIL unsigned_busy[%0d]: got %0d cycles (busy now %b) want %0d", i, busyc, bus32.busy, exp_lat(32, 1'b0, {32'b0, tb[i]})); else n_pass++;
    end
  endtask

  task automatic test_signed;
    bit          ts[3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] ta[3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb[3] = '{32'd6, 32'h8000_0000, 32'h8000_0000};
    int edges, busyc;
    logic [63:0] exp;
    for (int i = 0; i < 3; i++) begin
      issue32(ts[i], ta[i], tb[i]);
      wait32(0, edges, busyc);
      exp = 'x;
      if (q32.size() != 0) exp = q32.pop_front();
      n_checks++; if (bus32.product !== exp) $display("FAIL signed_product[%0d]: got %h want %h", i, bus32.product, exp); else n_pass++;
      n_checks++; if (edges != exp_lat(32, ts[i], {32'b0, tb[i]})) $display("FAIL signed_latency[%0d]: got %0d want %0d", i, edges, exp_lat(32, ts[i], {32'b0, tb[i]})); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int edges, busyc;
    logic [63:0] exp;
    issue32(1'b0, 32'd125, 32'd25);
    wait32(3, edges, busyc);
    exp = 'x;
    if (q32.size() != 0) exp = q32.pop_front();
    n_checks++; if (bus32.product !== exp) $display("FAIL b2b_first_product: got %h want %h", bus32.product, exp); else n_pass++;
    n_checks++; if (edges != exp_lat(32, 1'b0, 64'd25)) $display("FAIL b2b_first_latency: got %0d want %0d", edges, exp_lat(32, 1'b0, 64'd25)); else n_pass++;
    // start on the done cycle
    issue32(1'b0, 32'd9, 32'd9);
    n_checks++; if (bus32.product !== 64'd3125) $display("FAIL b2b_product_held: got %h want %h", bus32.product, 64'd3125); else n_pass++;
    wait32(0, edges, busyc);
    exp = 'x;
    if (q32.size() != 0) exp = q32.pop_front();
    n_checks++; if (bus32.product !== exp) $display("FAIL b2b_second_product: got %h want %h", bus32.product, exp); else n_pass++;
    n_checks++; if (edges != exp_lat(32, 1'b0, 64'd9)) $display("FAIL b2b_second_latency: got %0d want %0d", edges, exp_lat(32, 1'b0, 64'd9)); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int edges, busyc, dones;
    logic [63:0] exp;
    issue32(1'b0, 32'd1, 32'h8000_0001);
    repeat (9) @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    q32.delete();
    n_checks++; if (bus32.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus32.busy); else n_pass++;
    n_checks++; if (bus32.done !== 1'b0) $display("FAIL abort_done: got %b want 0", bus32.done); else n_pass++;
    n_checks++; if (bus32.product !== 64'd0) $display("FAIL abort_product: got %h want 0", bus32.product); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus32.done === 1'b1 || bus32.busy === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) $display("FAIL abort_no_done: got %0d busy/done cycles want 0", dones); else n_pass++;
    issue32(1'b0, 32'd3, 32'd5);
    wait32(0, edges, busyc);
    exp = 'x;
    if (q32.size() != 0) exp = q32.pop_front();
    n_checks++; if (bus32.product !== exp) $display("FAIL abort_next_product: got %h want %h", bus32.product, exp); else n_pass++;
    n_checks++; if (edges != exp_lat(32, 1'b0, 64'd5)) $display("FAIL abort_next_latency: got %0d want %0d", edges, exp_lat(32, 1'b0, 64'd5)); else n_pass++;
  endtask

  task automatic test_width8;
    bit         ts[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] ta[5] = '{8'hFF, 8'hFF, 8'h37, 8'hA5, 8'h80};
    logic [7:0] tb[5] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 8'h80};
    int edges;
    logic [15:0] exp;
    for (int i = 0; i < 5; i++) begin
      issue8(ts[i], ta[i], tb[i]);
      wait8(edges);
      exp = 'x;
      if (q8.size() != 0) exp = q8.pop_front();
      n_checks++; if (bus8.product !== exp) $display("FAIL w8_product[%0d]: got %h want %h", i, bus8.product, exp); else n_pass++;
      n_checks++; if (edges != exp_lat(8, ts[i], {56'b0, tb[i]})) $display("FAIL w8_latency[%0d]: got %0d want %0d", i, edges, exp_lat(8, ts[i], {56'b0, tb[i]})); else n_pass++;
    end
  endtask

  task automatic test_random;
    int edges, busyc;
    bit s;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 6; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      issue32(s, a, b);
      wait32(0, edges, busyc);
      exp = 'x;
      if (q32.size() != 0) exp = q32.pop_front();
      n_checks++; if (bus32.product !== exp) $display("FAIL random_product[%0d]: s=%0d a=%h b=%h got %h want %h", i, s, a, b, bus32.product, exp); else n_pass++;
      n_checks++; if (edges != exp_lat(32, s, {32'b0, b})) $display("FAIL random_latency[%0d]: got %0d want %0d", i, edges, exp_lat(32, s, {32'b0, b})); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_reset_abort();
    test_width8();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
